outport_hex_display: RTL and testbench



---
 rtl/outport_hex_display_pkg.sv | 32 +++
 rtl/outport_hex_display_hex.sv | 12 +
 rtl/outport_hex_display.sv | 150 +++++++++++++++
 tb/tb_outport_hex_display.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/outport_hex_display_pkg.sv
// Shared types and constants for the outport hex display.
// Segment order is {g,f,e,d,c,b,a}, active low.
package outport_hex_display_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_GAP  = 2'd1,
    ST_SHOW = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,
    7'b0000110,
    7'b0100001,
    7'b1000110,
    7'b0000011,
    7'b0001000,
    7'b0010000,
    7'b0000000,
    7'b1111000,
    7'b0000010,
    7'b0010010,
    7'b0011001,
    7'b0110000,
    7'b0100100,
    7'b1111001,
    7'b1000000
  };

endpackage

// File: rtl/outport_hex_display_hex.sv
// Nibble to active-low 7-segment pattern.
// Pure table lookup, no state.
module hex_to_seven_seg
  import outport_hex_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG[nib];

endmodule

// File: rtl/outport_hex_display.sv
// Multiplexed hex display of the CPU outport value.
// Frame-synchronous capture, dead time, leading-zero blanking.
module outport_hex_display
  import outport_hex_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_DIV     = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           outport_data,
  input  logic                  enable,
  input  logic                  blank_lz,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  update
);

  localparam int SW   = 4 * NUM_DIGITS;
  localparam int CMAX = (CLK_DIV > DEAD_CYCLES)
                        ? CLK_DIV : DEAD_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int DW   = (NUM_DIGITS > 1)
                        ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] GAP_LAST  = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   digit_q, digit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   shadow_q, shadow_d;
  logic [SW-1:0]   frame_val;
  logic            update_d;
  logic            capture;

  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]            nib;
  logic [6:0]            hex_seg;
  logic                  blanked;
  logic                  lit;

  assign frame_val = outport_data[SW-1:0];

  // State, position, counter and shadow registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_OFF;
      digit_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      update   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      update   <= update_d;
    end
  end

  // Scan sequencing; shadow only reloads at a frame boundary
  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    capture  = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (enable) begin
          state_d = ST_GAP;
          digit_d = '0;
          cnt_d   = '0;
          capture = 1'b1;
        end
      end
      ST_GAP: begin
        if (!enable) begin
          state_d = ST_OFF;
          digit_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          state_d = ST_OFF;
          digit_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == SHOW_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          if (digit_q == DIG_LAST) begin
            digit_d = '0;
            capture = 1'b1;
          end else begin
            digit_d = digit_q + DW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        digit_d = '0;
        cnt_d   = '0;
      end
    endcase
    update_d = capture && (frame_val != shadow_q);
    if (capture) shadow_d = frame_val;
  end

  // upper_zero[i]: shadow nibbles i..top are all zero
  always_comb begin
    logic acc;
    acc        = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc           = acc && (shadow_q[4*i +: 4] == 4'h0);
      upper_zero[i] = acc;
    end
  end

  assign nib = 4'(shadow_q >> {digit_q, 2'b00});

  hex_to_seven_seg u_hex (
    .nib   (nib),
    .seg_n (hex_seg)
  );

  // Moore decode of segments and the single active anode
  always_comb begin
    blanked = blank_lz && (digit_q != '0)
              && upper_zero[digit_q];
    lit     = (state_q == ST_SHOW) && !blanked;
    seg_n   = lit ? hex_seg : SEG_OFF;
    an_n    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_n[i] = !(lit && (digit_q == DW'(i)));
    end
  end

endmodule

// File: tb/tb_outport_hex_display.sv
// Directed bench for outport_hex_display.
// CLK_DIV=4, DEAD_CYCLES=1, NUM_DIGITS=8: 40-cycle frame.
module tb_outport_hex_display;

  localparam int ND = 8;
  localparam int CD = 4;
  localparam int DC = 1;

  logic          clk;
  logic          reset;
  logic [31:0]   outport_data;
  logic          enable;
  logic          blank_lz;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;
  logic          update;

  int  checks;
  int  errors;
  bit  mon_on;

  outport_hex_display #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (CD),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .outport_data (outport_data),
    .enable       (enable),
    .blank_lz     (blank_lz),
    .seg_n        (seg_n),
    .an_n         (an_n),
    .update       (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'b1000000;
      4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;
      4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;
      4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;
      4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0010000;
      4'hA: seg_of = 7'b0001000;
      4'hB: seg_of = 7'b0000011;
      4'hC: seg_of = 7'b1000110;
      4'hD: seg_of = 7'b0100001;
      4'hE: seg_of = 7'b0000110;
      default: seg_of = 7'b0001110;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_on)
      chk("onehot", 32'($countones(~an_n) <= 1), 32'd1);
  end

  task automatic win(input string tag,
                     input logic [7:0] an,
                     input logic [6:0] sg,
                     input logic up,
                     input int n);
    repeat (n) begin
      @(negedge clk);
      chk({tag, "_an"}, an_n, an);
      chk({tag, "_seg"}, seg_n, sg);
      chk({tag, "_upd"}, update, up);
    end
  endtask

  task automatic frame(input logic [31:0] val,
                       input bit blk,
                       input bit upd0,
                       input int lo,
                       input int hi);
    for (int d = lo; d <= hi; d++) begin
      logic [3:0] nb;
      bit         bl;
      logic [7:0] an;
      logic [6:0] sg;
      nb = 4'(val >> (4 * d));
      bl = blk && (d > 0) && ((val >> (4 * d)) == 0);
      an = bl ? 8'hFF : ~(8'h01 << d);
      sg = bl ? 7'h7F : seg_of(nb);
      win($sformatf("gap%0d", d), 8'hFF, 7'h7F,
          (d == 0) ? upd0 : 1'b0, DC);
      win($sformatf("show%0d", d), an, sg, 1'b0, CD);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    mon_on       = 0;
    reset        = 1'b1;
    enable       = 1'b0;
    blank_lz     = 1'b0;
    outport_data = 32'h0;
    repeat (2) @(negedge clk);
    win("rst0", 8'hFF, 7'h7F, 1'b0, 1);
    reset  = 1'b0;
    mon_on = 1;

    enable       = 1'b1;
    outport_data = 32'h12345678;
    frame(32'h12345678, 0, 1, 0, 1);
    outport_data = 32'hDEADBEEF;
    frame(32'h12345678, 0, 0, 2, 7);
    frame(32'hDEADBEEF, 0, 1, 0, 7);

    outport_data = 32'h0000002A;
    blank_lz     = 1'b1;
    frame(32'h0000002A, 1, 1, 0, 7);
    outport_data = 32'h0;
    frame(32'h0, 1, 1, 0, 7);
    frame(32'h0, 1, 0, 0, 7);

    outport_data = 32'h12345678;
    blank_lz     = 1'b0;
    frame(32'h12345678, 0, 1, 0, 4);
    win("gap5", 8'hFF, 7'h7F, 1'b0, DC);
    win("show5", 8'hDF, 7'b0110000, 1'b0, 2);
    enable = 1'b0;
    win("off", 8'hFF, 7'h7F, 1'b0, 2);
    enable = 1'b1;
    frame(32'h12345678, 0, 0, 0, 1);

    win("gap2", 8'hFF, 7'h7F, 1'b0, DC);
    win("show2", 8'hFB, 7'b0000010, 1'b0, 2);
    reset = 1'b1;
    win("rst1", 8'hFF, 7'h7F, 1'b0, 1);
    reset = 1'b0;
    frame(32'h12345678, 0, 1, 0, 0);

    reset        = 1'b1;
    enable       = 1'b0;
    outport_data = 32'h0;
    blank_lz     = 1'b1;
    win("rst2", 8'hFF, 7'h7F, 1'b0, 1);
    reset  = 1'b0;
    enable = 1'b1;
    frame(32'h0, 1, 0, 0, 7);

    mon_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
